calc_key_sequencer: RTL
=======================

Name: calc_key_sequencer

Overview:
- Input stage that sits directly upstream of the 4-bit signed calculator (add/sub/abs with overflow-to-HEX0).
- Conditions the raw active-low KEY[2:0] push-buttons: 2-FF synchronizer, per-key debounce, press (falling-edge) detection.
- On a press, snapshots SW[7:4]/SW[3:0] as signed operands A/B and issues one operation over a valid/ready handshake to the calculator core.
- Presses that arrive while an operation is still pending are dropped and counted.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive stable cycles required to accept a level change. Board build uses 1000000.
- CNT_W, 20: debounce counter width. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- WIDTH, 4: operand width, two's complement.

Ports:
- CLOCK_50  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- KEY  in  3  raw push-buttons, active-low. KEY[0]=add, KEY[1]=subtract, KEY[2]=absolute value (of A).
- SW  in  2*WIDTH  raw switches. SW[7:4]=A, SW[3:0]=B.
- op_ready  in  1  calculator core accepts the current operation.
- op_valid  out  1  operation pending; A, B and OP are stable while high.
- OP  out  2  00 none, 01 add, 10 sub, 11 abs.
- A  out  WIDTH  latched operand A.
- B  out  WIDTH  latched operand B.
- drop_cnt  out  4  saturating count of presses dropped while busy.

Behaviour:
- Reset (synchronous, active-high; wins over all other events):
  - sync FFs and debounced state = 3'b111 (released); counters = 0.
  - A = 0, B = 0, OP = 00, op_valid = 0, drop_cnt = 0, FSM = IDLE.
- Synchronizer: KEY passes through two FFs per bit. SW is not synchronized; it is sampled only at capture.
- Debounce, per key:
  - If synced ≠ stable, the counter increments; otherwise it clears to 0.
  - When the counter reaches DEBOUNCE_CYCLES-1 while a mismatch persists, stable takes the synced value and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes stable.
- Press event: stable transitions 1→0 (one-cycle pulse). A release (0→1) is not an event. A key held through reset becomes a press after debounce.
- Same-cycle events: if several press events occur together, priority is KEY[0] > KEY[1] > KEY[2]. Losers are discarded and not counted.
- FSM IDLE:
  - On a press event: A ← SW[7:4], B ← SW[3:0], OP ← code; op_valid = 1 next cycle; go to VALID.
  - Otherwise OP = 00.
- FSM VALID:
  - A, B and OP are held; op_valid = 1.
  - If op_ready = 1: transfer occurs; next cycle op_valid = 0, OP = 00, A/B retain their values, FSM = IDLE.
  - Any press event in VALID, including the transfer cycle itself, is dropped: drop_cnt += 1, saturating at 15.
- Latency: if KEY is first sampled low at edge t and held, the synced bit is low at t+2, stable goes low at t+1+DEBOUNCE_CYCLES, and op_valid is high from t+2+DEBOUNCE_CYCLES.
- Minimum transfer period is 2 cycles (capture, then accept). op_ready may be held high permanently.
- Operand values are passed through unmodified, with no arithmetic here. Overflow detection is the core's job. -8 (4'b1000) must pass intact.

Test Plan (DEBOUNCE_CYCLES=4):
1. Reset, SW=8'h35, KEY[0] held low from edge 10, op_ready=1 → op_valid high exactly at edge 16 for one cycle; OP=01, A=3, B=5; drop_cnt=0.
2. SW=8'h7F (A=7, B=-1), KEY[1] low for 2 cycles then high → no op_valid ever. Then hold KEY[1] low 10 cycles → one op with OP=10, A=7, B=4'hF; release generates nothing.
3. op_ready=0, KEY[2] press with SW=8'h80 → OP=11, A=4'h8, B=0, held 20 cycles. Second KEY[0] press during the hold → drop_cnt=1, outputs unchanged. Raise op_ready → op_valid low next cycle.
4. KEY[0] and KEY[2] fall on the same edge → a single op with OP=01; drop_cnt unchanged.
5. op_ready=0, pending op, assert reset for 1 cycle with KEY[1] still held → all outputs 0 after reset. After a further 2+DEBOUNCE_CYCLES cycles, a new OP=10 op appears.
6. op_ready=0, 17 presses while in VALID → drop_cnt saturates at 15.

Source files
------------

// File: rtl/calc_key_sequencer.sv
// Key conditioning front end for the 4-bit calculator: synchronizes and debounces KEY[2:0],
// turns presses into single operations and hands them to the core over valid/ready.
module calc_key_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = 20,
    parameter int unsigned WIDTH           = 4
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic [2:0]         KEY,
    input  logic [2*WIDTH-1:0] SW,
    input  logic               op_ready,
    output logic               op_valid,
    output logic [1:0]         OP,
    output logic [WIDTH-1:0]   A,
    output logic [WIDTH-1:0]   B,
    output logic [3:0]         drop_cnt
);

    typedef enum logic [0:0] {StIdle, StValid} state_e;

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [2:0]       sync1_q, sync2_q;
    logic [2:0]       stable_q, stable_d;
    logic [2:0]       press_q, fall_d;
    logic [CNT_W-1:0] cnt_q [3];
    logic [CNT_W-1:0] cnt_d [3];

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [1:0]       op_q, op_d;
    logic [3:0]       drop_q, drop_d;

    // Counter clears by default; it only advances while the synced level disagrees with stable.
    always_comb begin
        stable_d = stable_q;
        fall_d   = '0;
        for (int i = 0; i < 3; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CntLast) begin
                    stable_d[i] = sync2_q[i];
                    fall_d[i]   = stable_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        drop_d  = drop_q;
        case (state_q)
            StIdle: begin
                op_d = 2'b00;
                if (|press_q) begin
                    a_d     = SW[2*WIDTH-1:WIDTH];
                    b_d     = SW[WIDTH-1:0];
                    op_d    = press_q[0] ? 2'b01 : (press_q[1] ? 2'b10 : 2'b11);
                    state_d = StValid;
                end
            end
            StValid: begin
                // A press during the accept cycle still counts as dropped.
                if ((|press_q) && (drop_q != 4'hF)) begin
                    drop_d = drop_q + 4'd1;
                end
                if (op_ready) begin
                    op_d    = 2'b00;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sync1_q  <= 3'b111;
            sync2_q  <= 3'b111;
            stable_q <= 3'b111;
            press_q  <= '0;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= '0;
            end
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= 2'b00;
            drop_q   <= '0;
        end else begin
            sync1_q  <= KEY;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            press_q  <= fall_d;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            drop_q   <= drop_d;
        end
    end

    assign op_valid = (state_q == StValid);
    assign OP       = op_q;
    assign A        = a_q;
    assign B        = b_q;
    assign drop_cnt = drop_q;

endmodule
